bram_clear: RTL and testbench
=============================

# bram_clear

Single-port synchronous block RAM that zero-fills its whole array after every reset before it accepts accesses. It sits under caches and tables, such as the instruction cache tag/data store, that need a known all-zero state after reset. Readiness is reported on `o_initialized`. Reads have a fixed one-cycle latency, so clients can rely on the address alone.

## Interface
Parameters:
- `WIDTH`, default 32: data word width in bits.
- `SIZE`, default 1024: number of words. Must be a power of two, ≥ 2.
- `ADDR_LSH`, default 2: right shift applied to `i_address` to form the word index. 0 means word-addressed.

Ports:
- `i_clock` in 1: rising-edge clock.
- `i_reset` in 1: asynchronous, active-low reset.
- `o_initialized` out 1: high once the clear sweep has completed.
- `i_request` in 1: access request, sampled every rising edge.
- `i_rw` in 1: 1 = write, 0 = read.
- `i_address` in 32: byte/word address. Index = (`i_address` >> `ADDR_LSH`) modulo `SIZE`; higher bits are ignored.
- `i_wdata` in WIDTH: write data.
- `o_rdata` out WIDTH: registered read data.
- `o_ready` out 1: registered acknowledge of the access accepted on the previous edge.

## Operation
- Reset (`i_reset`=0, async):
  - clear counter = 0, `o_initialized`=0, `o_ready`=0, `o_rdata`=0.
  - Array contents are not modified while reset is held.
- Clear state (CLEAR):
  - After reset release, each rising edge writes 0 to entry `counter`, then increments the counter.
  - User requests are ignored: no write, no read, `o_ready` stays 0, `o_rdata` stays 0.
  - On the edge that clears entry SIZE-1, the block enters RUN and `o_initialized` goes to 1.
- Run state (RUN):
  - `o_initialized` stays 1 until the next reset.
  - Read (`i_request`=1, `i_rw`=0) at edge N: `o_rdata` = mem[index] after edge N, `o_ready`=1.
  - Write (`i_request`=1, `i_rw`=1) at edge N: mem[index] = `i_wdata`. `o_ready`=1 after edge N.
  - A write is read-first: `o_rdata` = the old contents of mem[index].
  - No request at an edge: `o_ready`=0 after that edge, and `o_rdata` holds its last value.
  - `i_request` held high continuously gives one access per cycle with `o_ready` high every cycle. There are no wait states.
- Reset mid-clear or mid-run:
  - Outputs drop immediately.
  - On release, the sweep restarts at index 0 and rewrites the whole array.
- Address aliasing: indices wrap modulo `SIZE`, so addresses differing only above the index bits hit the same entry.

## Timing
- Clear duration: exactly `SIZE` rising edges after reset deassertion. `o_initialized` is visible high after edge `SIZE`.
- Read latency: 1 cycle. Data for the address presented before edge N is valid after edge N.
- Write-to-read: a read of the same index at edge N+1 returns data written at edge N.
- Throughput: 1 access per cycle in RUN.
- All outputs are registered. No combinational path from inputs to outputs.
- Storage must infer vendor block RAM: a single synchronous port, no asynchronous read.

## Test plan
- Reset and clear, with `SIZE`=16, `ADDR_LSH`=2:
  - Release reset, then hold `i_request`=1, `i_rw`=0.
  - Required: `o_initialized` low for edges 1..15 and high after edge 16.
  - Required: `o_ready`=0 and `o_rdata`=0 throughout the sweep.
- Write/read back:
  - Write 0xDEADBEEF at address 0x8, then read 0x8 on the next cycle.
  - Required: `o_rdata`=0xDEADBEEF with `o_ready`=1 one edge after the read.
  - Required: the write cycle returns old data 0.
- Re-clear:
  - Fill all 16 entries with nonzero data, pulse `i_reset` low mid-run, wait for `o_initialized`.
  - Required: every entry reads back 0.
- Reset mid-clear:
  - Assert reset at sweep edge 7 and release it.
  - Required: `o_initialized` is asserted exactly 16 edges after the second release.
- Aliasing and back-to-back:
  - Write 0x1 to address 0x4, then 0x2 to address 0x44 (index 1 with SIZE=16).
  - Read 0x4 with `i_request` held high.
  - Required: `o_rdata`=0x2 and `o_ready` high each cycle.
- Idle:
  - Drop `i_request` for one cycle.
  - Required: `o_ready`=0 for that cycle and `o_rdata` unchanged.

Source files
------------

// File: rtl/bram_clear.sv
// Single-port synchronous block RAM that zero-fills its whole array after every reset
// before it accepts accesses. Reads have one cycle of latency and a write returns the old word.
module bram_clear #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 1024,
  parameter int ADDR_LSH = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  output logic             o_initialized,
  input  logic             i_request,
  input  logic             i_rw,
  input  logic [31:0]      i_address,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_ready
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_count;
  logic [AW-1:0]    w_count_nxt;
  logic [AW-1:0]    w_index;
  logic [AW-1:0]    w_mem_addr;
  logic             w_mem_we;
  logic             w_access;
  logic [WIDTH-1:0] w_mem_wdata;
  logic [WIDTH-1:0] r_mem_q;
  logic             r_have_data;
  logic             r_ready;
  logic [WIDTH-1:0] r_mem [SIZE];

  // Higher address bits fall away in the truncation, which gives the modulo-SIZE aliasing.
  assign w_index = AW'(i_address >> ADDR_LSH);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_CLEAR;
      r_count     <= {AW{1'b0}};
      r_ready     <= 1'b0;
      r_have_data <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_ready     <= w_access;
      r_have_data <= r_have_data | w_access;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_mem_addr  = w_index;
    w_mem_we    = 1'b0;
    w_mem_wdata = i_wdata;
    w_access    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_addr  = r_count;
        w_mem_we    = 1'b1;
        w_mem_wdata = {WIDTH{1'b0}};
        w_count_nxt = r_count + AW'(1);
        if (r_count == AW'(SIZE - 1)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_RUN: begin
        w_access = i_request;
        w_mem_we = i_request & i_rw;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_count_nxt = {AW{1'b0}};
      end
    endcase
  end

  // Plain synchronous port with no reset so it maps onto block RAM; the write is gated
  // by reset so the array is left untouched while reset is held.
  always_ff @(posedge i_clock) begin
    if (w_mem_we && i_reset) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
    if (w_access) begin
      r_mem_q <= r_mem[w_mem_addr];
    end
  end

  // Until the first access after reset the RAM output register holds stale data, so mask it.
  assign o_rdata       = r_have_data ? r_mem_q : {WIDTH{1'b0}};
  assign o_ready       = r_ready;
  assign o_initialized = (r_state == ST_RUN);

endmodule

// File: tb/tb_bram_clear.sv
// Self-checking bench for bram_clear (SIZE=16, ADDR_LSH=2): directed table, corner sequences
// and randomized traffic against an array model that counts edges since reset release.
module tb_bram_clear;

  localparam int W   = 32;
  localparam int N   = 16;
  localparam int LSH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          rw;
  logic [31:0]   addr;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic          init;
  logic          ready;

  always #5 clk = ~clk;

  bram_clear #(.WIDTH(W), .SIZE(N), .ADDR_LSH(LSH)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .o_initialized(init),
    .i_request    (req),
    .i_rw         (rw),
    .i_address    (addr),
    .i_wdata      (wdata),
    .o_rdata      (rdata),
    .o_ready      (ready)
  );

  typedef struct {
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic [31:0] exp_rdata;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_mem [N];
  int          m_swept;
  logic [31:0] m_rdata;
  logic        m_ready;
  vec_t        tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("initialized", {31'd0, init}, {31'd0, (m_swept >= N)});
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    chk("rdata", rdata, m_rdata);
  endtask

  // Model: the first N edges after release zero entry 0..N-1; afterwards each edge is one access.
  task automatic tick();
    int idx;
    if (m_swept < N) begin
      m_mem[m_swept] = 32'd0;
      m_swept++;
      m_ready = 1'b0;
    end else if (req) begin
      idx = int'((addr >> LSH) % N);
      m_rdata = m_mem[idx];
      if (rw) m_mem[idx] = wdata;
      m_ready = 1'b1;
    end else begin
      m_ready = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int hold);
    rst_n   = 1'b0;
    m_swept = 0;
    m_ready = 1'b0;
    m_rdata = 32'd0;
    #1;
    check_outputs();
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    tbl[0] = '{1'b1, 1'b1, 32'h8,  32'hDEADBEEF, 1'b1, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h8,  32'h0,        1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 32'h4,  32'h1,        1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 32'h44, 32'h2,        1'b1, 32'h1};
    tbl[4] = '{1'b1, 1'b0, 32'h4,  32'h0,        1'b1, 32'h2};
    tbl[5] = '{1'b1, 1'b0, 32'h4,  32'h0,        1'b1, 32'h2};
    tbl[6] = '{1'b0, 1'b0, 32'h8,  32'h0,        1'b0, 32'h2};
    tbl[7] = '{1'b1, 1'b0, 32'h48, 32'h0,        1'b1, 32'hDEADBEEF};
    for (int i = 0; i < N; i++) m_mem[i] = 32'd0;

    req = 1'b0; rw = 1'b0; addr = 32'd0; wdata = 32'd0;
    do_reset(2);

    // Sweep with reads requested throughout: all ignored, initialized after edge 16.
    req = 1'b1; rw = 1'b0; addr = $urandom;
    for (int i = 1; i <= N; i++) begin
      tick();
      chk("sweep_rdata", rdata, 32'd0);
    end

    // Directed table: write/readback, read-first, aliasing, back-to-back, idle hold.
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; rw = tbl[i].rw; addr = tbl[i].addr; wdata = tbl[i].wdata;
      tick();
      chk("tbl_ready", {31'd0, ready}, {31'd0, tbl[i].exp_ready});
      chk("tbl_rdata", rdata, tbl[i].exp_rdata);
    end

    // Re-clear: fill with nonzero data, reset mid-run, every entry must read back zero.
    for (int i = 0; i < N; i++) begin
      req = 1'b1; rw = 1'b1;
      addr = (32'(i) << LSH) | (32'($urandom_range(0, 255)) << 6);
      wdata = $urandom | 32'd1;
      tick();
    end
    do_reset(3);
    req = 1'b0;
    repeat (N) tick();
    for (int i = 0; i < N; i++) begin
      req = 1'b1; rw = 1'b0;
      addr = (32'(i) << LSH) | (32'($urandom_range(0, 255)) << 6);
      tick();
      chk("reclear_zero", rdata, 32'd0);
    end

    // Reset at sweep edge 7, then count edges to initialized after the second release.
    do_reset(1);
    req = 1'b1; rw = 1'b1; wdata = 32'hFFFF_FFFF;
    repeat (7) tick();
    do_reset(2);
    edges = 0;
    while (!init && edges < 40) begin
      tick();
      edges++;
    end
    chk("mid_clear_len", 32'(edges), 32'd16);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      rw    = 1'($urandom_range(0, 1));
      addr  = $urandom;
      wdata = $urandom;
      if ($urandom_range(0, 199) == 0) do_reset(1);
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
